// File: rtl/cpucore_axi_rsp_pkg.sv
// Shared types and constants for the cpucore AXI responder: response codes,
// beat geometry and the read/write engine state encodings.
package cpucore_axi_rsp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         BEAT_BYTES  = 16;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // INCR bursts only: every beat advances by one full data word.
  function automatic logic [31:0] next_beat_addr(input logic [31:0] addr);
    return addr + 32'(BEAT_BYTES);
  endfunction

endpackage

// File: rtl/cpucore_axi_rsp_mem.sv
// DEPTH x DATA_W storage with one byte-enable write port and one registered,
// read-first read port. The whole array clears on synchronous reset.
module cpucore_axi_rsp_mem #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_strb,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the array has a reset because integrators rely on it reading back as
  // zero after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      // Read samples the pre-write contents: same-cycle collisions are read-first.
      if (rd_en) rd_data_q <= mem_q[rd_idx];
      if (wr_en) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_strb[b]) mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/cpucore_axi_responder.sv
// AXI slave responder backed by a byte-enable register file; independent read
// and write engines, one outstanding burst each. Define AXIRSP_RANGE_CHK_EN to error out-of-range beats.
module cpucore_axi_responder
  import cpucore_axi_rsp_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ID_W   = 8,
  parameter int DEPTH  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         slv_AWADDR,
  input  logic [ID_W-1:0]     slv_AWID,
  input  logic                slv_AWVALID,
  output logic                slv_AWREADY,
  input  logic [3:0]          slv_AWSIZE,
  input  logic [3:0]          slv_AWLEN,
  input  logic [31:0]         slv_ARADDR,
  input  logic [ID_W-1:0]     slv_ARID,
  input  logic                slv_ARVALID,
  output logic                slv_ARREADY,
  input  logic [3:0]          slv_ARSIZE,
  input  logic [3:0]          slv_ARLEN,
  input  logic [DATA_W-1:0]   slv_WDATA,
  input  logic [DATA_W/8-1:0] slv_WSTRB,
  input  logic                slv_WLAST,
  input  logic                slv_WVALID,
  output logic                slv_WREADY,
  output logic [ID_W-1:0]     slv_BID,
  output logic [1:0]          slv_BRESP,
  output logic                slv_BVALID,
  input  logic                slv_BREADY,
  output logic [ID_W-1:0]     slv_RID,
  output logic [DATA_W-1:0]   slv_RDATA,
  output logic [1:0]          slv_RRESP,
  output logic                slv_RLAST,
  output logic                slv_RVALID,
  input  logic                slv_RREADY
);

  localparam int IDX_W = $clog2(DEPTH);

  // Write engine state
  wr_state_e       wr_state_q, wr_state_d;
  logic            awready_q, awready_d;
  logic            wready_q, wready_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [ID_W-1:0] bid_q, bid_d;
  logic [31:0]     waddr_q, waddr_d;
  logic [3:0]      wlen_q, wlen_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic            werr_q, werr_d;

  // Read engine state
  rd_state_e       rd_state_q, rd_state_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic            rlast_q, rlast_d;
  logic            roor_q, roor_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [31:0]     raddr_q, raddr_d;
  logic [3:0]      rlen_q, rlen_d;
  logic [3:0]      rcnt_q, rcnt_d;

  logic              mem_wr_en, mem_rd_en;
  logic [IDX_W-1:0]  mem_rd_idx;
  logic [DATA_W-1:0] mem_rd_data;
  logic              w_last_beat, w_beat_err;
  logic              waddr_oor, araddr_oor, raddr_oor;

  // SIZE is informational only; byte lanes are governed entirely by WSTRB.
  logic unused_size;
  assign unused_size = ^{slv_AWSIZE, slv_ARSIZE};

`ifdef AXIRSP_RANGE_CHK_EN
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * BEAT_BYTES);
  assign waddr_oor  = (waddr_q    >= ADDR_LIMIT);
  assign araddr_oor = (slv_ARADDR >= ADDR_LIMIT);
  assign raddr_oor  = (raddr_q    >= ADDR_LIMIT);
`else
  assign waddr_oor  = 1'b0;
  assign araddr_oor = 1'b0;
  assign raddr_oor  = 1'b0;
`endif

  // NOTE: every signal driven here gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_state_d  = wr_state_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    bid_d       = bid_q;
    waddr_d     = waddr_q;
    wlen_d      = wlen_q;
    wcnt_d      = wcnt_q;
    werr_d      = werr_q;
    mem_wr_en   = 1'b0;
    w_last_beat = (wcnt_q == wlen_q);
    w_beat_err  = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (slv_AWVALID && awready_q) begin
          wr_state_d = W_DATA;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          bid_d      = slv_AWID;
          waddr_d    = slv_AWADDR;
          wlen_d     = slv_AWLEN;
          wcnt_d     = '0;
          werr_d     = 1'b0;
        end
      end
      W_DATA: begin
        if (slv_WVALID && wready_q) begin
          mem_wr_en  = !waddr_oor;
          // The beat count, not WLAST, ends the burst; a disagreeing WLAST only flags an error.
          w_beat_err = (slv_WLAST != w_last_beat) || waddr_oor;
          werr_d     = werr_q | w_beat_err;
          waddr_d    = next_beat_addr(waddr_q);
          wcnt_d     = wcnt_q + 4'd1;
          if (w_last_beat) begin
            wr_state_d = W_RESP;
            wready_d   = 1'b0;
            bvalid_d   = 1'b1;
            bresp_d    = (werr_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (slv_BREADY) begin
          wr_state_d = W_IDLE;
          bvalid_d   = 1'b0;
          bresp_d    = RESP_OKAY;
          awready_d  = 1'b1;
        end
      end
      default: begin
        wr_state_d = W_IDLE;
        awready_d  = 1'b1;
        wready_d   = 1'b0;
        bvalid_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    roor_d     = roor_q;
    rid_d      = rid_q;
    raddr_d    = raddr_q;
    rlen_d     = rlen_q;
    rcnt_d     = rcnt_q;
    mem_rd_en  = 1'b0;
    mem_rd_idx = '0;
    case (rd_state_q)
      R_IDLE: begin
        if (slv_ARVALID && arready_q) begin
          rd_state_d = R_DATA;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          mem_rd_en  = 1'b1;
          mem_rd_idx = slv_ARADDR[IDX_W+3:4];
          raddr_d    = next_beat_addr(slv_ARADDR);
          rid_d      = slv_ARID;
          rlen_d     = slv_ARLEN;
          rcnt_d     = '0;
          rlast_d    = (slv_ARLEN == 4'd0);
          roor_d     = araddr_oor;
        end
      end
      R_DATA: begin
        // Fetch the next beat on the accepting edge so beats stream without bubbles.
        if (slv_RREADY && rvalid_q) begin
          if (rlast_q) begin
            rd_state_d = R_IDLE;
            rvalid_d   = 1'b0;
            rlast_d    = 1'b0;
            roor_d     = 1'b0;
            arready_d  = 1'b1;
          end else begin
            mem_rd_en  = 1'b1;
            mem_rd_idx = raddr_q[IDX_W+3:4];
            raddr_d    = next_beat_addr(raddr_q);
            rcnt_d     = rcnt_q + 4'd1;
            rlast_d    = ((rcnt_q + 4'd1) == rlen_q);
            roor_d     = raddr_oor;
          end
        end
      end
      default: begin
        rd_state_d = R_IDLE;
        arready_d  = 1'b1;
        rvalid_d   = 1'b0;
        rlast_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      bid_q      <= '0;
      waddr_q    <= '0;
      wlen_q     <= '0;
      wcnt_q     <= '0;
      werr_q     <= 1'b0;
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      roor_q     <= 1'b0;
      rid_q      <= '0;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rcnt_q     <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      bid_q      <= bid_d;
      waddr_q    <= waddr_d;
      wlen_q     <= wlen_d;
      wcnt_q     <= wcnt_d;
      werr_q     <= werr_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      roor_q     <= roor_d;
      rid_q      <= rid_d;
      raddr_q    <= raddr_d;
      rlen_q     <= rlen_d;
      rcnt_q     <= rcnt_d;
    end
  end

  cpucore_axi_rsp_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_wr_en),
    .wr_idx  (waddr_q[IDX_W+3:4]),
    .wr_data (slv_WDATA),
    .wr_strb (slv_WSTRB),
    .rd_en   (mem_rd_en),
    .rd_idx  (mem_rd_idx),
    .rd_data (mem_rd_data)
  );

  assign slv_AWREADY = awready_q;
  assign slv_WREADY  = wready_q;
  assign slv_BVALID  = bvalid_q;
  assign slv_BRESP   = bresp_q;
  assign slv_BID     = bid_q;
  assign slv_ARREADY = arready_q;
  assign slv_RVALID  = rvalid_q;
  assign slv_RLAST   = rlast_q;
  assign slv_RID     = rid_q;
  assign slv_RDATA   = roor_q ? '0 : mem_rd_data;
  assign slv_RRESP   = roor_q ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_cpucore_axi_responder.sv
// Directed self-checking bench for cpucore_axi_responder: single beats, wrap,
// strobes, WLAST errors, stalled reads, collisions, reset and optional range check.
module tb_cpucore_axi_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  slv_AWADDR, slv_ARADDR;
  logic [7:0]   slv_AWID, slv_ARID;
  logic         slv_AWVALID, slv_AWREADY, slv_ARVALID, slv_ARREADY;
  logic [3:0]   slv_AWSIZE, slv_AWLEN, slv_ARSIZE, slv_ARLEN;
  logic [127:0] slv_WDATA;
  logic [15:0]  slv_WSTRB;
  logic         slv_WLAST, slv_WVALID, slv_WREADY;
  logic [7:0]   slv_BID, slv_RID;
  logic [1:0]   slv_BRESP, slv_RRESP;
  logic         slv_BVALID, slv_BREADY;
  logic [127:0] slv_RDATA;
  logic         slv_RLAST, slv_RVALID, slv_RREADY;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] wbuf [16];
  logic [127:0] rexp [16];

  always #5 clk = ~clk;

  cpucore_axi_responder dut (
    .clk         (clk),
    .rst         (rst),
    .slv_AWADDR  (slv_AWADDR),
    .slv_AWID    (slv_AWID),
    .slv_AWVALID (slv_AWVALID),
    .slv_AWREADY (slv_AWREADY),
    .slv_AWSIZE  (slv_AWSIZE),
    .slv_AWLEN   (slv_AWLEN),
    .slv_ARADDR  (slv_ARADDR),
    .slv_ARID    (slv_ARID),
    .slv_ARVALID (slv_ARVALID),
    .slv_ARREADY (slv_ARREADY),
    .slv_ARSIZE  (slv_ARSIZE),
    .slv_ARLEN   (slv_ARLEN),
    .slv_WDATA   (slv_WDATA),
    .slv_WSTRB   (slv_WSTRB),
    .slv_WLAST   (slv_WLAST),
    .slv_WVALID  (slv_WVALID),
    .slv_WREADY  (slv_WREADY),
    .slv_BID     (slv_BID),
    .slv_BRESP   (slv_BRESP),
    .slv_BVALID  (slv_BVALID),
    .slv_BREADY  (slv_BREADY),
    .slv_RID     (slv_RID),
    .slv_RDATA   (slv_RDATA),
    .slv_RRESP   (slv_RRESP),
    .slv_RLAST   (slv_RLAST),
    .slv_RVALID  (slv_RVALID),
    .slv_RREADY  (slv_RREADY)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    slv_AWADDR = '0; slv_AWID = '0; slv_AWVALID = 0; slv_AWSIZE = 4'd4; slv_AWLEN = '0;
    slv_ARADDR = '0; slv_ARID = '0; slv_ARVALID = 0; slv_ARSIZE = 4'd4; slv_ARLEN = '0;
    slv_WDATA = '0; slv_WSTRB = '0; slv_WLAST = 0; slv_WVALID = 0;
    slv_BREADY = 0; slv_RREADY = 0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] id, input logic [3:0] len,
                             input logic [15:0] strb, input int wlast_at, input logic [1:0] exp_resp,
                             input string tag);
    int n;
    slv_AWADDR = addr; slv_AWID = id; slv_AWLEN = len; slv_AWVALID = 1;
    n = 0;
    while (!slv_AWREADY && n < 50) begin step(); n++; end
    n_cmp++;
    if (slv_AWREADY !== 1'b1) begin
      n_bad++; $display("FAIL %s aw_timeout: AWREADY=%b required 1", tag, slv_AWREADY);
    end
    step();
    slv_AWVALID = 0;
    for (int i = 0; i <= int'(len); i++) begin
      slv_WDATA = wbuf[i]; slv_WSTRB = strb; slv_WLAST = (i == wlast_at); slv_WVALID = 1;
      n = 0;
      while (!slv_WREADY && n < 50) begin step(); n++; end
      n_cmp++;
      if (slv_WREADY !== 1'b1) begin
        n_bad++; $display("FAIL %s w_timeout beat %0d: WREADY=%b required 1", tag, i, slv_WREADY);
      end
      step();
    end
    slv_WVALID = 0; slv_WLAST = 0;
    n_cmp++;
    if ({slv_BVALID, slv_BID, slv_BRESP} !== {1'b1, id, exp_resp}) begin
      n_bad++;
      $display("FAIL %s bresp: BVALID/BID/BRESP=%b/%h/%b required 1/%h/%b",
               tag, slv_BVALID, slv_BID, slv_BRESP, id, exp_resp);
    end
    slv_BREADY = 1;
    step();
    slv_BREADY = 0;
    n_cmp++;
    if ({slv_BVALID, slv_AWREADY} !== 2'b01) begin
      n_bad++; $display("FAIL %s b_done: BVALID/AWREADY=%b/%b required 0/1", tag, slv_BVALID, slv_AWREADY);
    end
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] id, input logic [3:0] len,
                            input logic [1:0] exp_resp, input bit rand_ready, input string tag);
    int beat, n;
    logic stalled;
    logic [138:0] held, cur;
    slv_ARADDR = addr; slv_ARID = id; slv_ARLEN = len; slv_ARVALID = 1;
    n = 0;
    while (!slv_ARREADY && n < 50) begin step(); n++; end
    step();
    slv_ARVALID = 0;
    beat = 0; n = 0; stalled = 0; held = '0;
    while (beat <= int'(len) && n < 400) begin
      cur = {slv_RDATA, slv_RID, slv_RRESP, slv_RLAST};
      if (stalled) begin
        n_cmp++;
        if (slv_RVALID !== 1'b1 || cur !== held) begin
          n_bad++; $display("FAIL %s stall_hold beat %0d: RVALID=%b beat %h held %h", tag, beat, slv_RVALID, cur, held);
        end
      end
      slv_RREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (slv_RVALID && slv_RREADY) begin
        n_cmp++;
        if (cur !== {rexp[beat], id, exp_resp, beat == int'(len)}) begin
          n_bad++;
          $display("FAIL %s beat %0d: RDATA/RID/RRESP/RLAST=%h/%h/%b/%b required %h/%h/%b/%b",
                   tag, beat, slv_RDATA, slv_RID, slv_RRESP, slv_RLAST,
                   rexp[beat], id, exp_resp, beat == int'(len));
        end
        beat++;
        stalled = 0;
      end else if (slv_RVALID) begin
        stalled = 1;
        held = cur;
      end
      step();
      n++;
    end
    slv_RREADY = 0;
    n_cmp++;
    if (beat != int'(len) + 1) begin
      n_bad++; $display("FAIL %s r_timeout: got %0d beats required %0d", tag, beat, int'(len) + 1);
    end
    n_cmp++;
    if ({slv_RVALID, slv_ARREADY} !== 2'b01) begin
      n_bad++; $display("FAIL %s r_done: RVALID/ARREADY=%b/%b required 0/1", tag, slv_RVALID, slv_ARREADY);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    n_cmp++;
    if ({slv_AWREADY, slv_ARREADY, slv_WREADY, slv_BVALID, slv_RVALID, slv_RLAST, slv_BRESP, slv_RDATA}
        !== {6'b110000, 2'b00, 128'h0}) begin
      n_bad++;
      $display("FAIL reset_state: AWR/ARR/WR/BV/RV/RL=%b%b%b%b%b%b BRESP=%b RDATA=%h required 110000 00 0",
               slv_AWREADY, slv_ARREADY, slv_WREADY, slv_BVALID, slv_RVALID, slv_RLAST, slv_BRESP, slv_RDATA);
    end
  endtask

  task automatic test_single();
    wbuf[0] = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    write_burst(32'h20, 8'h5A, 4'd0, 16'hFFFF, 0, 2'b00, "single_wr");
    rexp[0] = wbuf[0];
    read_burst(32'h20, 8'h11, 4'd0, 2'b00, 0, "single_rd");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) wbuf[i] = {4{32'hA0A0_0000 + 32'(i)}};
    write_burst(32'h3F0, 8'h21, 4'd3, 16'hFFFF, 3, 2'b00, "wrap_wr");
    for (int i = 0; i < 4; i++) rexp[i] = {4{32'hA0A0_0000 + 32'(i)}};
    read_burst(32'h3F0, 8'h22, 4'd3, 2'b00, 0, "wrap_rd");
    for (int i = 0; i < 3; i++) rexp[i] = {4{32'hA0A0_0001 + 32'(i)}};
    read_burst(32'h000, 8'h23, 4'd2, 2'b00, 0, "wrap_word0");
  endtask

  task automatic test_wlast_err();
    for (int i = 0; i < 3; i++) wbuf[i] = {4{32'hE000_0000 + 32'(i)}};
    write_burst(32'h80, 8'h31, 4'd2, 16'hFFFF, 1, 2'b10, "wlast_early");
    for (int i = 0; i < 3; i++) rexp[i] = {4{32'hE000_0000 + 32'(i)}};
    read_burst(32'h80, 8'h32, 4'd2, 2'b00, 0, "wlast_data");
  endtask

  task automatic test_strobe();
    wbuf[0] = {128{1'b1}};
    write_burst(32'h40, 8'h41, 4'd0, 16'hFFFF, 0, 2'b00, "strb_fill");
    wbuf[0] = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    write_burst(32'h40, 8'h42, 4'd0, 16'h000F, 0, 2'b00, "strb_wr");
    rexp[0] = {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h76543210};
    read_burst(32'h40, 8'h43, 4'd0, 2'b00, 0, "strb_rd");
  endtask

  task automatic test_read_stall();
    for (int i = 0; i < 8; i++) begin
      wbuf[i] = {$urandom, $urandom, $urandom, $urandom};
      rexp[i] = wbuf[i];
    end
    write_burst(32'h100, 8'h51, 4'd7, 16'hFFFF, 7, 2'b00, "stall_fill");
    read_burst(32'h100, 8'h52, 4'd7, 2'b00, 1, "stall_rd");
  endtask

  task automatic test_back_to_back();
    logic [127:0] c_old, a_old, b_new;
    c_old = 128'hC0C0C0C0_11111111_22222222_33333333;
    a_old = 128'hA5A5A5A5_44444444_55555555_66666666;
    b_new = 128'hB7B7B7B7_77777777_88888888_99999999;
    wbuf[0] = c_old; wbuf[1] = a_old;
    write_burst(32'h1F0, 8'h61, 4'd1, 16'hFFFF, 1, 2'b00, "coll_fill");
    // AW to word 0x20 and a 2-beat read from 0x1F0 accepted together; the
    // second read fetch lands in the same cycle as the write beat to 0x20.
    slv_AWADDR = 32'h200; slv_AWID = 8'h33; slv_AWLEN = 4'd0; slv_AWVALID = 1;
    slv_ARADDR = 32'h1F0; slv_ARID = 8'h44; slv_ARLEN = 4'd1; slv_ARVALID = 1;
    step();
    slv_AWVALID = 0; slv_ARVALID = 0;
    slv_WDATA = b_new; slv_WSTRB = 16'hFFFF; slv_WLAST = 1; slv_WVALID = 1;
    slv_RREADY = 1;
    n_cmp++;
    if ({slv_RVALID, slv_RDATA, slv_RID, slv_RRESP, slv_RLAST} !== {1'b1, c_old, 8'h44, 2'b00, 1'b0}) begin
      n_bad++; $display("FAIL coll_beat0: RV/RDATA/RID/RL=%b/%h/%h/%b required 1/%h/44/0",
                        slv_RVALID, slv_RDATA, slv_RID, slv_RLAST, c_old);
    end
    step();
    slv_WVALID = 0; slv_WLAST = 0;
    n_cmp++;
    if ({slv_RVALID, slv_RDATA, slv_RLAST} !== {1'b1, a_old, 1'b1}) begin
      n_bad++; $display("FAIL coll_read_first: RV/RDATA/RL=%b/%h/%b required 1/%h/1",
                        slv_RVALID, slv_RDATA, slv_RLAST, a_old);
    end
    step();
    slv_RREADY = 0;
    n_cmp++;
    if ({slv_RVALID, slv_ARREADY} !== 2'b01) begin
      n_bad++; $display("FAIL coll_r_done: RVALID/ARREADY=%b/%b required 0/1", slv_RVALID, slv_ARREADY);
    end
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if ({slv_BVALID, slv_BID, slv_BRESP} !== {1'b1, 8'h33, 2'b00}) begin
        n_bad++; $display("FAIL b_hold cyc %0d: BVALID/BID/BRESP=%b/%h/%b required 1/33/00",
                          c, slv_BVALID, slv_BID, slv_BRESP);
      end
      step();
    end
    slv_BREADY = 1;
    step();
    slv_BREADY = 0;
    n_cmp++;
    if ({slv_BVALID, slv_AWREADY} !== 2'b01) begin
      n_bad++; $display("FAIL coll_b_done: BVALID/AWREADY=%b/%b required 0/1", slv_BVALID, slv_AWREADY);
    end
    rexp[0] = b_new;
    read_burst(32'h200, 8'h45, 4'd0, 2'b00, 0, "coll_after");
  endtask

  task automatic test_reset_mid_burst();
    int n;
    slv_AWADDR = 32'h300; slv_AWID = 8'h71; slv_AWLEN = 4'd3; slv_AWVALID = 1;
    step();
    slv_AWVALID = 0;
    slv_WDATA = {4{32'h7777_7777}}; slv_WSTRB = 16'hFFFF; slv_WVALID = 1;
    n = 0;
    while (!slv_WREADY && n < 50) begin step(); n++; end
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    idle_inputs();
    n_cmp++;
    if ({slv_AWREADY, slv_BVALID, slv_WREADY, slv_ARREADY, slv_RVALID} !== 5'b10010) begin
      n_bad++; $display("FAIL rst_mid: AWR/BV/WR/ARR/RV=%b%b%b%b%b required 10010",
                        slv_AWREADY, slv_BVALID, slv_WREADY, slv_ARREADY, slv_RVALID);
    end
    repeat (3) begin
      n_cmp++;
      if (slv_BVALID !== 1'b0) begin
        n_bad++; $display("FAIL rst_no_b: BVALID=%b required 0", slv_BVALID);
      end
      step();
    end
    rexp[0] = '0;
    read_burst(32'h20, 8'h72, 4'd0, 2'b00, 0, "rst_cleared");
  endtask

`ifdef AXIRSP_RANGE_CHK_EN
  task automatic test_range_chk();
    wbuf[0] = {4{32'h1234_5678}};
    write_burst(32'h000, 8'h81, 4'd0, 16'hFFFF, 0, 2'b00, "range_fill");
    wbuf[0] = {4{32'hBAD0_BAD0}};
    write_burst(32'h400, 8'h82, 4'd0, 16'hFFFF, 0, 2'b10, "range_wr");
    rexp[0] = '0;
    read_burst(32'h400, 8'h83, 4'd0, 2'b10, 0, "range_rd");
    rexp[0] = {4{32'h1234_5678}};
    read_burst(32'h000, 8'h84, 4'd0, 2'b00, 0, "range_no_alias");
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
`ifndef AXIRSP_RANGE_CHK_EN
    test_wrap();
`endif
    test_wlast_err();
    test_strobe();
    test_read_stall();
    test_back_to_back();
    test_reset_mid_burst();
`ifdef AXIRSP_RANGE_CHK_EN
    test_range_chk();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
